// File: rtl/make_chars.sv
// Prints a latched byte as two ASCII hex characters into a UART TX FIFO,
// optionally followed by CR/LF when MAKE_CHARS_CRLF_EN is defined.
module make_chars #(
  parameter int unsigned HEX_UPPER = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       send,
  input  logic       tx_full,
  output logic [7:0] tx_data,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] DIGIT_BASE  = 8'h30;
  // Offset so that nibble 0xA lands on 'A' (0x41) or 'a' (0x61).
  localparam logic [DW-1:0] LETTER_BASE = (HEX_UPPER != 0) ? 8'h37 : 8'h57;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    CR   = 3'd3,
    LF   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  state_t        next_c;
  logic [DW-1:0] val_q, val_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          wr_en_q, wr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] char_c;

  function automatic logic [DW-1:0] nib_char(input logic [3:0] nib);
    if (nib < 4'hA) nib_char = DIGIT_BASE + DW'(nib);
    else            nib_char = LETTER_BASE + DW'(nib);
  endfunction

  // Character for the current state and the state that follows it.
  always_comb begin
    char_c = '0;
    next_c = IDLE;
    case (state_q)
      HI: begin
        char_c = nib_char(val_q[7:4]);
        next_c = LO;
      end
      LO: begin
        char_c = nib_char(val_q[3:0]);
`ifdef MAKE_CHARS_CRLF_EN
        next_c = CR;
`else
        next_c = IDLE;
`endif
      end
`ifdef MAKE_CHARS_CRLF_EN
      CR: begin
        char_c = 8'h0D;
        next_c = LF;
      end
      LF: begin
        char_c = 8'h0A;
        next_c = IDLE;
      end
`endif
      default: begin
        char_c = '0;
        next_c = IDLE;
      end
    endcase
  end

  // Write when FIFO has room and no write is in flight; advance after the write cycle.
  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (send) begin
          val_d   = value;
          state_d = HI;
        end
      end
      default: begin
        if (wr_en_q) begin
          state_d = next_c;
          done_d  = (next_c == IDLE);
        end else if (!tx_full) begin
          wr_en_d   = 1'b1;
          tx_data_d = char_c;
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      val_q     <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      tx_data_q <= tx_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_data = tx_data_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_make_chars.sv
// Directed bench for make_chars: upper- and lower-case instances share stimulus
// and are checked cycle by cycle against hand-computed characters.
module tb_make_chars;

`ifdef MAKE_CHARS_CRLF_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic       send;
  logic       tx_full;
  logic [7:0] txd [2];
  logic       wr  [2];
  logic       bsy [2];
  logic       dn  [2];

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_ch  [2][4];
  logic [7:0] exp_txd [2];

  typedef struct {
    logic [7:0] v;
    int         stall;
    logic [7:0] hu, lu, hl, ll;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  make_chars #(.HEX_UPPER(1)) u_up (
    .clk(clk), .rst(rst), .value(value), .send(send), .tx_full(tx_full),
    .tx_data(txd[0]), .wr_en(wr[0]), .busy(bsy[0]), .done(dn[0])
  );

  make_chars #(.HEX_UPPER(0)) u_lo (
    .clk(clk), .rst(rst), .value(value), .send(send), .tx_full(tx_full),
    .tx_data(txd[1]), .wr_en(wr[1]), .busy(bsy[1]), .done(dn[1])
  );

  task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d act=%h exp=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] nib(input logic [3:0] n, input bit upper);
    if (n < 4'hA) nib = 8'h30 + 8'(n);
    else          nib = (upper ? 8'h41 : 8'h61) + 8'(n - 4'hA);
  endfunction

  task automatic chk_idle(input string name);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_txd"}, i, txd[i], exp_txd[i]);
      chk({name, "_wr"}, i, 8'(wr[i]), 8'h0);
      chk({name, "_busy"}, i, 8'(bsy[i]), 8'h0);
      chk({name, "_done"}, i, 8'(dn[i]), 8'h0);
    end
  endtask

  // Called at a negedge; accepts v at the next edge N and follows the sequence.
  task automatic run_seq(input vec_t t);
    int last;
    exp_ch[0][0] = t.hu; exp_ch[0][1] = t.lu;
    exp_ch[1][0] = t.hl; exp_ch[1][1] = t.ll;
    for (int i = 0; i < 2; i++) begin
      exp_ch[i][2] = 8'h0D;
      exp_ch[i][3] = 8'h0A;
    end
    send = 1'b1; value = t.v; tx_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0; value = ~t.v;
    last = t.stall + 2 * NCH;
    for (int c = 1; c <= last + 1; c++) begin
      bit ew;
      tx_full = (c <= t.stall);
      ew = (c >= t.stall + 2) && (c <= last) && (((c - t.stall) % 2) == 0);
      for (int i = 0; i < 2; i++) begin
        if (ew) exp_txd[i] = exp_ch[i][(c - t.stall - 2) / 2];
        chk("seq_wr", i, 8'(wr[i]), 8'(ew));
        chk("seq_txd", i, txd[i], exp_txd[i]);
        chk("seq_busy", i, 8'(bsy[i]), 8'(c <= last));
        chk("seq_done", i, 8'(dn[i]), 8'(c == last + 1));
      end
      @(negedge clk);
    end
    tx_full = 1'b0;
  endtask

  initial begin
    int per;
    logic [7:0] cur;
    tbl[0] = '{8'h3A, 0,  8'h33, 8'h41, 8'h33, 8'h61};
    tbl[1] = '{8'hF0, 0,  8'h46, 8'h30, 8'h66, 8'h30};
    tbl[2] = '{8'hAB, 0,  8'h41, 8'h42, 8'h61, 8'h62};
    tbl[3] = '{8'h00, 0,  8'h30, 8'h30, 8'h30, 8'h30};
    tbl[4] = '{8'h9F, 10, 8'h39, 8'h46, 8'h39, 8'h66};
    tbl[5] = '{8'hC5, 3,  8'h43, 8'h35, 8'h63, 8'h35};

    rst = 1'b1; send = 1'b0; value = 8'h00; tx_full = 1'b0;
    exp_txd[0] = 8'h00; exp_txd[1] = 8'h00;
    @(negedge clk); @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_seq(tbl[k]);

    // Held send with a changing value: each sequence prints its own latched byte.
    per = 2 * NCH + 1;
    send = 1'b1; value = 8'h5C; cur = 8'h5C;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 3 * per; c++) begin
      int o;
      o = (c - 1) % per + 1;
      for (int i = 0; i < 2; i++) begin
        logic [7:0] ch;
        bit ew;
        ew = (o % 2 == 0) && (o <= 2 * NCH);
        case (o / 2)
          1: ch = nib(cur[7:4], i == 0);
          2: ch = nib(cur[3:0], i == 0);
          3: ch = 8'h0D;
          default: ch = 8'h0A;
        endcase
        if (ew) exp_txd[i] = ch;
        chk("b2b_wr", i, 8'(wr[i]), 8'(ew));
        chk("b2b_txd", i, txd[i], exp_txd[i]);
        chk("b2b_busy", i, 8'(bsy[i]), 8'(o != per));
        chk("b2b_done", i, 8'(dn[i]), 8'(o == per));
      end
      value = 8'(8'h17 * c + 8'h21);
      send = (c < 3 * per);
      if (o == per) cur = value;
      @(negedge clk);
    end
    send = 1'b0;
    chk_idle("b2b_end");

    // Reset in the middle of a sequence abandons it cleanly.
    send = 1'b1; value = 8'h7E;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_txd[0] = 8'h00; exp_txd[1] = 8'h00;
    for (int c = 0; c < 8; c++) begin
      chk_idle("midrst");
      @(negedge clk);
    end
    run_seq(tbl[2]);

    // Reset wins over a simultaneous send.
    rst = 1'b1; send = 1'b1; value = 8'h12;
    @(negedge clk);
    rst = 1'b0; send = 1'b0;
    exp_txd[0] = 8'h00; exp_txd[1] = 8'h00;
    chk_idle("rst_prio");
    @(negedge clk);
    chk_idle("rst_prio2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/make_chars.md
MAKE_CHARS -- requirements
Module: make_chars

Interface
REQ-001 Parameter HEX_UPPER, default 1, selects hex letter case: 1 gives 'A'-'F' (0x41-0x46), 0 gives 'a'-'f' (0x61-0x66).
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 value  input  8  byte to print; sampled only on send acceptance.
REQ-005 send  input  1  request to print value; level-sampled each cycle.
REQ-006 tx_full  input  1  UART TX FIFO full flag; 1 blocks writes.
REQ-007 tx_data  output  8  ASCII character presented to the TX FIFO; registered.
REQ-008 wr_en  output  1  TX FIFO write strobe; registered; one-cycle pulse per character.
REQ-009 busy  output  1  high while a print sequence is in progress; registered.
REQ-010 done  output  1  one-cycle pulse marking sequence completion; registered.

Function
REQ-011 FSM states: IDLE, HI, LO, CR, LF; in the CR/LF-disabled build, CR and LF are unreachable.
REQ-012 In IDLE, send=1 at a rising edge latches value into an internal register, moves to HI, and sets busy=1 from the next cycle.
REQ-013 send is ignored while busy=1; the latched byte does not change until the next acceptance.
REQ-014 Nibble encoding: 0x0-0x9 -> 0x30-0x39; 0xA-0xF -> letters per HEX_UPPER.
REQ-015 In state S (HI, LO, CR, LF), the block writes the state's character when tx_full=0 and wr_en=0 in the current cycle.
REQ-016 Writing a character sets wr_en=1 and tx_data=char for exactly the next cycle, then advances the FSM.
REQ-017 wr_en is forced to 0 in the cycle after any write, giving a mandatory one-cycle gap so the FIFO full flag can update.
REQ-018 Character order: HI = upper nibble char, LO = lower nibble char, CR = 0x0D, LF = 0x0A.
REQ-019 While tx_full=1, the block stalls indefinitely in its current state with wr_en=0 and tx_data held; no character is dropped or duplicated.
REQ-020 Zero-stall latency, taking send accepted at edge N: the first character's wr_en occurs in cycle N+2, with each subsequent character 2 cycles later.
REQ-021 busy stays 1 through the final character's wr_en cycle; in the next cycle, done=1, busy=0 and state=IDLE.
REQ-022 A send present in the done cycle is accepted, permitting back-to-back sequences.
REQ-023 tx_data holds its last value whenever wr_en=0.

Reset
REQ-024 rst=1 forces state=IDLE and tx_data=0x00, wr_en=0, busy=0, done=0, and latched value=0x00 at the next edge.
REQ-025 rst asserted mid-sequence abandons remaining characters, with no further wr_en and no done pulse.
REQ-026 rst has priority over a simultaneous send.

Configuration
REQ-027 Macro MAKE_CHARS_CRLF_EN defined: after LO, the FSM proceeds to CR then LF, emitting 4 characters per sequence.
REQ-028 Macro MAKE_CHARS_CRLF_EN undefined: LO transitions directly to completion, emitting 2 characters per sequence, with no CR/LF logic present.

Verification
REQ-029 No CRLF, HEX_UPPER=1, value=0x3A, send pulse accepted at edge N, tx_full=0 -> wr_en with tx_data=0x33 at N+2 and 0x41 at N+4; done=1 at N+5; busy 1 over N+1..N+4.
REQ-030 CRLF build, value=0xF0, same timing -> chars 0x46@N+2, 0x30@N+4, 0x0D@N+6, 0x0A@N+8; done at N+9.
REQ-031 HEX_UPPER=0, value=0xAB -> characters 0x61 then 0x62.
REQ-032 tx_full=1 for cycles N+1..N+10, then 0 -> no wr_en during the stall; first char wr_en at N+12; total write count unchanged.
REQ-033 send held high continuously with value changing every cycle -> each sequence prints only the value latched at its acceptance; new sequence is accepted in each done cycle.
REQ-034 rst asserted at N+3 of a sequence -> all outputs 0 from N+4, no further wr_en, no done; next send starts a clean sequence.
